rice_stream_encoder: RTL and testbench

- Encoder counterpart of the Rice decode path: accepts signed 16-bit residuals, folds each to unsigned, and serialises the Rice codeword one bit per clock.
- Bit order: unary quotient as q zeros, then a single '1' stop bit, then k remainder bits MSB-first (FLAC residual coding).
- Sits between the residual generator and the bitstream packer.
- Output bit rate is throttled by iEnable, the downstream bit-accept strobe.

---
 rtl/rice_stream_encoder_if.sv | 25 ++
 rtl/rice_stream_encoder.sv | 95 +++++++++
 tb/tb_rice_stream_encoder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rice_stream_encoder_if.sv
// Residual-in / serial-bit-out bundle for the Rice encoder.
// The producer side drives the residual and the downstream accept strobe.
interface rice_stream_encoder_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int PARAM_WIDTH = 4
);
  logic                   iEnable;
  logic                   iValid;
  logic [DATA_WIDTH-1:0]  iData;
  logic [PARAM_WIDTH-1:0] iRiceParam;
  logic                   oReady;
  logic                   oBit;
  logic                   oBitValid;
  logic                   oDone;

  modport master (
    output iEnable, iValid, iData, iRiceParam,
    input  oReady, oBit, oBitValid, oDone
  );

  modport slave (
    input  iEnable, iValid, iData, iRiceParam,
    output oReady, oBit, oBitValid, oDone
  );
endinterface

// File: rtl/rice_stream_encoder.sv
// Folds signed residuals and emits the Rice codeword one bit per
// accepted cycle: q zeros, a '1' stop bit, then k remainder bits MSB-first.
module rice_stream_encoder #(
  parameter int DATA_WIDTH  = 16,
  parameter int PARAM_WIDTH = 4
) (
  input  logic iClock,
  input  logic iReset,
  rice_stream_encoder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, UNARY, STOP, LSB
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0]  cnt, cnt_n;
  logic [DATA_WIDTH-1:0]  rem, rem_n;
  logic [PARAM_WIDTH-1:0] k, k_n;
  logic [PARAM_WIDTH-1:0] idx, idx_n;

  logic [DATA_WIDTH-1:0] u, q, r;
  logic last, ready, load;

  // zig-zag fold: sign bit smeared across the word
  assign u = (bus.iData << 1) ^ {DATA_WIDTH{bus.iData[DATA_WIDTH-1]}};
  assign q = u >> bus.iRiceParam;
  assign r = u & ((DATA_WIDTH'(1) << bus.iRiceParam) - DATA_WIDTH'(1));

  assign last = (state == STOP && k == '0) ||
                (state == LSB && idx == '0);
  assign ready = !iReset &&
                 (state == IDLE || (last && bus.iEnable));
  assign load = bus.iValid && ready;

  assign bus.oReady    = ready;
  assign bus.oBitValid = (state != IDLE);
  assign bus.oDone     = last;

  always_comb begin
    bus.oBit = 1'b0;
    unique case (state)
      IDLE:  bus.oBit = 1'b0;
      UNARY: bus.oBit = 1'b0;
      STOP:  bus.oBit = 1'b1;
      LSB:   bus.oBit = rem[idx];
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    k_n     = k;
    idx_n   = idx;
    unique case (state)
      IDLE: ;
      UNARY:
        if (bus.iEnable) begin
          if (cnt == DATA_WIDTH'(1)) state_n = STOP;
          else cnt_n = cnt - DATA_WIDTH'(1);
        end
      STOP:
        if (bus.iEnable && k != '0) state_n = LSB;
      LSB:
        if (bus.iEnable && idx != '0)
          idx_n = idx - PARAM_WIDTH'(1);
    endcase
    if (last && bus.iEnable && !load) state_n = IDLE;
    // a load on the final bit chains the next word with no bubble
    if (load) begin
      state_n = (q != '0) ? UNARY : STOP;
      cnt_n   = q;
      rem_n   = r;
      k_n     = bus.iRiceParam;
      idx_n   = bus.iRiceParam - PARAM_WIDTH'(1);
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      k     <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      k     <= k_n;
      idx   <= idx_n;
    end
  end
endmodule

// File: tb/tb_rice_stream_encoder.sv
// Self-checking bench for rice_stream_encoder: vector table, hand
// sequences and randomized streams against a codeword-level model.
module tb_rice_stream_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rice_stream_encoder_if bus ();

  rice_stream_encoder dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] wq_x[$];
  logic [3:0]         wq_k[$];
  bit                 eb[$];
  bit                 el[$];

  typedef struct {
    logic signed [15:0] x;
    logic [3:0]         k;
    int                 len;
    logic [31:0]        bits;
    int                 mode;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_push(input int x, input int k);
    int u, q, r;
    u = (x >= 0) ? 2 * x : -2 * x - 1;
    q = u / (1 << k);
    r = u % (1 << k);
    wq_x.push_back(16'(x));
    wq_k.push_back(4'(k));
    repeat (q) begin
      eb.push_back(1'b0);
      el.push_back(1'b0);
    end
    eb.push_back(1'b1);
    el.push_back(k == 0);
    for (int i = k - 1; i >= 0; i--) begin
      eb.push_back(((r >> i) & 1) != 0);
      el.push_back(i == 0);
    end
  endfunction

  task automatic run_stream(input int mode, input string name);
    int cyc, budget, nbits;
    bit en, pen, pval, pb, pd, xb, xl;
    cyc   = 0;
    nbits = eb.size();
    budget = (mode == 0) ? nbits + 10 : nbits * 4 + 20;
    pen = 1'b1;
    pval = 1'b0;
    pb = 1'b0;
    pd = 1'b0;
    while ((eb.size() > 0 || wq_x.size() > 0) && cyc < budget) begin
      @(negedge clk);
      case (mode)
        0: en = 1'b1;
        1: en = (cyc % 3) == 0;
        default: en = 1'($urandom_range(0, 1));
      endcase
      bus.iEnable = en;
      bus.iValid  = (wq_x.size() > 0);
      if (wq_x.size() > 0) begin
        bus.iData      = wq_x[0];
        bus.iRiceParam = wq_k[0];
      end else begin
        bus.iData      = 16'($urandom);
        bus.iRiceParam = 4'($urandom);
      end
      #1;
      if (!pen && pval) begin
        check({name, " stall valid"}, 32'(bus.oBitValid), 32'(pval));
        check({name, " stall bit"}, 32'(bus.oBit), 32'(pb));
        check({name, " stall done"}, 32'(bus.oDone), 32'(pd));
      end
      if (bus.oBitValid && en) begin
        if (eb.size() == 0) begin
          check({name, " extra bit"}, 32'd1, 32'd0);
        end else begin
          xb = eb.pop_front();
          xl = el.pop_front();
          check({name, " bit"}, 32'(bus.oBit), 32'(xb));
          check({name, " done"}, 32'(bus.oDone), 32'(xl));
          if (xl) check({name, " ready on last"}, 32'(bus.oReady), 32'd1);
        end
      end
      if (bus.iValid && bus.oReady) begin
        void'(wq_x.pop_front());
        void'(wq_k.pop_front());
      end
      pen  = en;
      pval = bus.oBitValid;
      pb   = bus.oBit;
      pd   = bus.oDone;
      cyc++;
    end
    bus.iValid = 1'b0;
    if (eb.size() > 0 || wq_x.size() > 0) begin
      check({name, " timeout bits left"}, 32'(eb.size()), 32'd0);
      eb.delete();
      el.delete();
      wq_x.delete();
      wq_k.delete();
    end
    if (mode == 0) check({name, " cycles"}, 32'(cyc), 32'(nbits + 1));
  endtask

  initial begin
    vecs[0] = '{x: 16'sd5,      k: 4'd2,  len: 5,  bits: 32'b00110,   mode: 0};
    vecs[1] = '{x: -16'sd3,     k: 4'd0,  len: 6,  bits: 32'b000001,  mode: 0};
    vecs[2] = '{x: -16'sd32768, k: 4'd15, len: 17, bits: 32'h0FFFF,   mode: 0};
    vecs[3] = '{x: 16'sd5,      k: 4'd2,  len: 5,  bits: 32'b00110,   mode: 1};
    vecs[4] = '{x: 16'sd0,      k: 4'd3,  len: 4,  bits: 32'b1000,    mode: 0};
    vecs[5] = '{x: 16'sd0,      k: 4'd0,  len: 1,  bits: 32'b1,       mode: 0};
    vecs[6] = '{x: 16'sd7,      k: 4'd3,  len: 5,  bits: 32'b01110,   mode: 2};

    rst = 1'b1;
    bus.iEnable = 1'b0;
    bus.iValid = 1'b0;
    bus.iData = '0;
    bus.iRiceParam = '0;
    #1;
    check("reset ready", 32'(bus.oReady), 32'd0);
    check("reset valid", 32'(bus.oBitValid), 32'd0);
    check("reset bit", 32'(bus.oBit), 32'd0);
    check("reset done", 32'(bus.oDone), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle ready", 32'(bus.oReady), 32'd1);
    check("idle valid", 32'(bus.oBitValid), 32'd0);

    for (int v = 0; v < 7; v++) begin
      wq_x.push_back(vecs[v].x);
      wq_k.push_back(vecs[v].k);
      for (int i = 0; i < vecs[v].len; i++) begin
        eb.push_back(vecs[v].bits[vecs[v].len - 1 - i]);
        el.push_back(i == vecs[v].len - 1);
      end
      run_stream(vecs[v].mode, $sformatf("vec%0d", v));
    end

    // back-to-back: x=0,k=3 then x=1,k=1 (u=2 -> 0,1,0)
    wq_x.push_back(16'sd0);
    wq_k.push_back(4'd3);
    wq_x.push_back(16'sd1);
    wq_k.push_back(4'd1);
    eb = '{1, 0, 0, 0, 0, 1, 0};
    el = '{0, 0, 0, 1, 0, 0, 1};
    run_stream(0, "b2b");

    // reset during second unary bit of x=-3,k=0
    @(negedge clk);
    bus.iEnable = 1'b1;
    bus.iValid = 1'b1;
    bus.iData = -16'sd3;
    bus.iRiceParam = 4'd0;
    #1;
    check("rst seq ready", 32'(bus.oReady), 32'd1);
    @(negedge clk);
    bus.iValid = 1'b0;
    #1;
    check("rst seq bit1 valid", 32'(bus.oBitValid), 32'd1);
    check("rst seq bit1", 32'(bus.oBit), 32'd0);
    @(negedge clk);
    #1;
    check("rst seq bit2 valid", 32'(bus.oBitValid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid rst valid", 32'(bus.oBitValid), 32'd0);
    check("mid rst ready", 32'(bus.oReady), 32'd0);
    check("mid rst done", 32'(bus.oDone), 32'd0);
    check("mid rst bit", 32'(bus.oBit), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_push(1, 0);
    run_stream(0, "after rst");

    // longest codeword: 65535 zeros then the stop bit
    model_push(-32768, 0);
    run_stream(0, "max q");

    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 5; w++) begin
        if ($urandom_range(0, 1) == 0)
          model_push(int'($urandom_range(0, 200)) - 100,
                     int'($urandom_range(0, 15)));
        else
          model_push(int'($signed(16'($urandom))),
                     int'($urandom_range(10, 15)));
      end
      run_stream((s % 2 == 0) ? 2 : 0, $sformatf("rand%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
